// File: rtl/serial_nibble_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_nibble_loader_pkg
// Description : Shared state encoding and nibble width for the serial loader.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_nibble_loader_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [NIBBLE_W-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_nibble_loader_bit_counter_2b.sv
`default_nettype none
// ============================================================================
// Module      : bit_counter_2b
// Description : 2-bit bit counter with clear, restart, enable and terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_counter_2b (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    input  logic en,
    output logic tc
);

    logic [1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_cnt <= 2'd0;
        end else if (restart) begin
            r_cnt <= 2'd0;
        end else if (en) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign tc = (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/serial_nibble_loader.sv
`default_nettype none
// ============================================================================
// Module      : serial_nibble_loader
// Description : Framed serial-to-parallel nibble loader with optional parity.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_nibble_loader
    import serial_nibble_loader_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                bit_valid,
    input  logic                bit_in,
    output logic [NIBBLE_W-1:0] d_out,
    output logic                ce_out,
    output logic                err,
    output logic                busy
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NIBBLE_W-1:0]   r_shift;
    logic [NIBBLE_W-1:0]   w_shift_nxt;
    logic [NIBBLE_W-1:0]   w_shifted;
    logic [NIBBLE_W-1:0]   r_d_out;
    logic [NIBBLE_W-1:0]   w_d_nxt;
    logic                  r_ce;
    logic                  w_ce_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  r_busy;
    logic                  w_cnt_en;
    logic                  w_tc;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shift[NIBBLE_W-2:0], bit_in};
        end else begin : g_lsb_first
            assign w_shifted = {bit_in, r_shift[NIBBLE_W-1:1]};
        end
    endgenerate

    // A start strobe always wins over a bit in the same cycle.
    assign w_cnt_en = (r_state == SHIFT) && bit_valid && !start;

    bit_counter_2b u_bit_counter (
        .clk     (clk),
        .clr     (clr),
        .restart (start),
        .en      (w_cnt_en),
        .tc      (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_d_nxt     = r_d_out;
        w_ce_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = '0;
                end
            end
            SHIFT: begin
                if (start) begin
                    w_shift_nxt = '0;
                end else if (bit_valid) begin
                    w_shift_nxt = w_shifted;
                    if (w_tc) begin
                        if (PARITY_EN) begin
                            w_state_nxt = PARITY;
                        end else begin
                            w_state_nxt = IDLE;
                            w_d_nxt     = w_shifted;
                            w_ce_nxt    = 1'b1;
                        end
                    end
                end
            end
            PARITY: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = '0;
                end else if (bit_valid) begin
                    w_state_nxt = IDLE;
                    if (bit_in == even_parity(r_shift)) begin
                        w_d_nxt  = r_shift;
                        w_ce_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_d_out <= '0;
            r_ce    <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_d_out <= w_d_nxt;
            r_ce    <= w_ce_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign d_out  = r_d_out;
    assign ce_out = r_ce;
    assign err    = r_err;
    assign busy   = r_busy;

endmodule
`default_nettype wire
